// File: rtl/prim_encoder_8to3_seq.sv
// Sequential 8-to-3 encoder: accepts a multi-hot request vector and walks it,
// returning the binary index of every set bit, one beat per index, in
// priority order over a valid/ready handshake.
module prim_encoder_8to3_seq #(
  parameter int IDX_W        = 3,
  parameter bit PRIORITY_LSB = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_vld,
  input  logic [(1<<IDX_W)-1:0] i_req,
  output logic                  o_req_rdy,
  output logic                  o_idx_vld,
  output logic [IDX_W-1:0]      o_idx,
  output logic                  o_last,
  input  logic                  i_idx_rdy,
  output logic                  o_zero
);

  localparam int N = 1 << IDX_W;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pend_q,  pend_d;
  logic           zero_q,  zero_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_last;

  // Priority-encode the pending mask; the last hit in scan order wins.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    enc_idx = '0;
    if (PRIORITY_LSB) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pend_q[i]) enc_idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pend_q[i]) enc_idx = IDX_W'(i);
      end
    end
    enc_last = ((pend_q & (pend_q - ONE)) == '0);
  end

  // Next-state logic: accept a vector in IDLE, retire one index per handshake in EMIT.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_vld) begin
          if (|i_req) begin
            pend_d  = i_req;
            state_d = ST_EMIT;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (i_idx_rdy) begin
          pend_d = pend_q & ~(ONE << enc_idx);
          if (enc_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs decode registered state; o_req_rdy is additionally held low during reset.
  always_comb begin
    o_req_rdy = i_rst_n && (state_q == ST_IDLE);
    o_idx_vld = (state_q == ST_EMIT);
    o_idx     = o_idx_vld ? enc_idx : '0;
    o_last    = o_idx_vld && enc_last;
    o_zero    = zero_q;
  end

endmodule
